// File: rtl/motor_pkg.sv
// Shared motor-control types: direction codes, bridge FSM state encoding and
// the default dead-time length.
package motor_pkg;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_FWD  = 2'b01;
  localparam logic [1:0] DIR_REV  = 2'b10;
  localparam logic [1:0] DIR_BAD  = 2'b11;

  localparam int DEAD_CYCLES_DEFAULT = 50000;

  typedef enum logic [2:0] {
    COAST = 3'd0,
    FWD   = 3'd1,
    REV   = 3'd2,
    DEAD  = 3'd3,
    BRAKE = 3'd4
  } state_t;

endpackage

// File: rtl/dead_timer.sv
// Loadable down counter that saturates at zero; done flags an expired count.
module dead_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/hbridge_dir_guard.sv
// H-bridge direction guard: forces a coast dead time on every exit from
// FWD/REV and rejects code 11. Define HBRIDGE_ACTIVE_BRAKE_EN to brake on stop.
module hbridge_dir_guard
  import motor_pkg::*;
#(
  parameter  int DEAD_CYCLES = DEAD_CYCLES_DEFAULT,
  localparam int CNT_W       = $clog2(DEAD_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] dir,
  input  logic       pwm,
  output logic       in_a,
  output logic       in_b,
  output logic       en,
  output logic       busy,
  output logic       cmd_err
);

  state_t     state;
  state_t     next_state;
  logic [1:0] dir_q;
  logic [1:0] dir_prev;
  logic       pwm_q;
  logic       load_dead;
  logic       dead_done;
  logic       a_d;
  logic       b_d;
  logic       en_d;

  dead_timer #(
    .CNT_W (CNT_W)
  ) u_dead_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_dead),
    .load_val (CNT_W'(DEAD_CYCLES - 1)),
    .done     (dead_done)
  );

  always_comb begin
    next_state = state;
    load_dead  = 1'b0;
    case (state)
      COAST: begin
        if (dir_q == DIR_FWD) begin
          next_state = FWD;
        end else if (dir_q == DIR_REV) begin
          next_state = REV;
`ifdef HBRIDGE_ACTIVE_BRAKE_EN
        end else if (dir_q == DIR_STOP) begin
          next_state = BRAKE;
`endif
        end
      end
      FWD: begin
        if (dir_q != DIR_FWD) begin
          next_state = DEAD;
          load_dead  = 1'b1;
        end
      end
      REV: begin
        if (dir_q != DIR_REV) begin
          next_state = DEAD;
          load_dead  = 1'b1;
        end
      end
      DEAD: begin
        // Runs to completion even if the old direction comes back.
        if (dead_done) begin
          next_state = COAST;
        end
      end
`ifdef HBRIDGE_ACTIVE_BRAKE_EN
      BRAKE: begin
        // Both low legs are on, so a drive direction must pass dead time first.
        if (dir_q == DIR_FWD || dir_q == DIR_REV) begin
          next_state = DEAD;
          load_dead  = 1'b1;
        end
      end
`endif
      default: begin
        next_state = COAST;
      end
    endcase
  end

  always_comb begin
    a_d  = 1'b0;
    b_d  = 1'b0;
    en_d = 1'b0;
    case (next_state)
      FWD: begin
        a_d  = 1'b1;
        en_d = pwm_q;
      end
      REV: begin
        b_d  = 1'b1;
        en_d = pwm_q;
      end
      BRAKE: begin
        a_d  = 1'b1;
        b_d  = 1'b1;
        en_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Outputs are registered alongside the state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= COAST;
      dir_q    <= DIR_STOP;
      dir_prev <= DIR_STOP;
      pwm_q    <= 1'b0;
      in_a     <= 1'b0;
      in_b     <= 1'b0;
      en       <= 1'b0;
      busy     <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      dir_q    <= dir;
      pwm_q    <= pwm;
      dir_prev <= dir_q;
      state    <= next_state;
      in_a     <= a_d;
      in_b     <= b_d;
      en       <= en_d;
      busy     <= (next_state == DEAD);
      cmd_err  <= (dir_q == DIR_BAD) && (dir_prev != DIR_BAD);
    end
  end

endmodule
